// File: rtl/seq_mux_nx1.sv
// N:1 registered selector with a manual-select mode and a scan mode that
// streams every input, one word per cycle, into a shared downstream MAC.
module seq_mux_nx1 #(
  parameter  int DATA_WIDTH = 12,
  parameter  int NUM_IN     = 8,
  localparam int SEL_W      = $clog2(NUM_IN)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_bus,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         start,
  input  logic                         hold,
  output logic [DATA_WIDTH-1:0]        out,
  output logic                         out_valid,
  output logic                         out_last,
  output logic                         busy,
  output logic                         sel_err
);

  localparam int             NWORDS   = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    vld_q, vld_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic [NWORDS-1:0][DATA_WIDTH-1:0] words;
  logic                    sel_oor;
  logic                    start_ok;

  // Pad the word table to a power of two; unused slots alias input 0 so an
  // out-of-range manual select lands on in[0] without extra muxing.
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    if (k < NUM_IN) begin : g_real
      assign words[k] = in_bus[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign words[k] = in_bus[DATA_WIDTH-1:0];
    end
  end

  assign sel_oor  = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
  // last_q marks the IDLE cycle right after a scan: start is refused there,
  // which guarantees a one-cycle out_valid gap between back-to-back scans.
  assign start_ok = mode && start && !last_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = SCAN;
      SCAN:    if (!hold && idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    out_d  = out_q;
    vld_d  = 1'b0;
    last_d = 1'b0;
    err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mode) begin
          out_d = words[sel];
          vld_d = 1'b1;
          err_d = sel_oor;
        end else if (start_ok) begin
          out_d = words[0];
          vld_d = 1'b1;
          idx_d = SEL_W'(1);
        end
      end
      SCAN: begin
        if (!hold) begin
          out_d = words[idx_q];
          vld_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            last_d = 1'b1;
            idx_d  = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;
  assign busy      = (state_q == SCAN);
  assign sel_err   = err_q;

endmodule

// File: tb/tb_seq_mux_nx1.sv
// Directed bench for seq_mux_nx1: a vector table on an 8-input instance plus
// hand sequences for reset, live data, and a 6-input instance.
module tb_seq_mux_nx1;

  localparam int DW = 12;

  logic          CLK, RST;
  logic [8*DW-1:0] in8;
  logic [6*DW-1:0] in6;
  logic          mode8, start8, hold8, mode6, start6, hold6;
  logic [2:0]    sel8, sel6;
  logic [DW-1:0] out8, out6;
  logic          v8, l8, b8, e8, v6, l6, b6, e6;

  int n_vec = 0;
  int n_bad = 0;

  seq_mux_nx1 #(.DATA_WIDTH(DW), .NUM_IN(8)) u8 (
    .CLK(CLK), .RST(RST), .in_bus(in8), .mode(mode8), .sel(sel8),
    .start(start8), .hold(hold8), .out(out8), .out_valid(v8),
    .out_last(l8), .busy(b8), .sel_err(e8));

  seq_mux_nx1 #(.DATA_WIDTH(DW), .NUM_IN(6)) u6 (
    .CLK(CLK), .RST(RST), .in_bus(in6), .mode(mode6), .sel(sel6),
    .start(start6), .hold(hold6), .out(out6), .out_valid(v6),
    .out_last(l6), .busy(b6), .sel_err(e6));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic       start;
    logic       hold;
    logic [DW-1:0] eout;
    logic       ev, el, eb, ee;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic m, logic [2:0] s, logic st, logic h,
                              logic [DW-1:0] o, logic v, logic l, logic b, logic e);
    vec_t t;
    t.mode = m; t.sel = s; t.start = st; t.hold = h;
    t.eout = o; t.ev = v; t.el = l; t.eb = b; t.ee = e;
    tbl.push_back(t);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk8(string nm, logic [DW-1:0] o, logic v, logic l, logic b, logic e);
    chk({nm, ".out"},   32'(out8), 32'(o));
    chk({nm, ".valid"}, 32'(v8),   32'(v));
    chk({nm, ".last"},  32'(l8),   32'(l));
    chk({nm, ".busy"},  32'(b8),   32'(b));
    chk({nm, ".err"},   32'(e8),   32'(e));
  endtask

  task automatic chk6(string nm, logic [DW-1:0] o, logic v, logic l, logic b, logic e);
    chk({nm, ".out"},   32'(out6), 32'(o));
    chk({nm, ".valid"}, 32'(v6),   32'(v));
    chk({nm, ".last"},  32'(l6),   32'(l));
    chk({nm, ".busy"},  32'(b6),   32'(b));
    chk({nm, ".err"},   32'(e6),   32'(e));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_data();
    for (int k = 0; k < 8; k++) in8[k*DW +: DW] = DW'(12'h100 + k);
    for (int k = 0; k < 6; k++) in6[k*DW +: DW] = DW'(12'h200 + k);
  endtask

  initial begin
    RST = 1'b0;
    mode8 = 0; sel8 = 0; start8 = 0; hold8 = 0;
    mode6 = 0; sel6 = 0; start6 = 0; hold6 = 0;
    load_data();

    // manual select 0..7; start/hold ignored in manual mode
    for (int k = 0; k < 8; k++)
      add(0, 3'(k), k == 3, k == 3, DW'(12'h100 + k), 1, 0, 0, 0);
    add(1, 0, 0, 0, 12'h107, 0, 0, 0, 0);
    // unstalled scan
    add(1, 0, 1, 0, 12'h100, 1, 0, 1, 0);
    for (int k = 1; k < 7; k++) add(1, 0, 0, 0, DW'(12'h100 + k), 1, 0, 1, 0);
    add(1, 0, 0, 0, 12'h107, 1, 1, 0, 0);
    add(1, 0, 0, 0, 12'h107, 0, 0, 0, 0);
    // scan with 2-cycle hold on 0x103
    add(1, 0, 1, 0, 12'h100, 1, 0, 1, 0);
    for (int k = 1; k < 4; k++) add(1, 0, 0, 0, DW'(12'h100 + k), 1, 0, 1, 0);
    add(1, 0, 0, 1, 12'h103, 0, 0, 1, 0);
    add(1, 0, 0, 1, 12'h103, 0, 0, 1, 0);
    for (int k = 4; k < 7; k++) add(1, 0, 0, 0, DW'(12'h100 + k), 1, 0, 1, 0);
    add(1, 0, 0, 0, 12'h107, 1, 1, 0, 0);
    add(1, 0, 0, 0, 12'h107, 0, 0, 0, 0);
    // start held high, mode dropped mid-scan, then back-to-back scan after a gap
    add(1, 0, 1, 0, 12'h100, 1, 0, 1, 0);
    add(0, 3, 1, 0, 12'h101, 1, 0, 1, 0);
    add(0, 5, 1, 0, 12'h102, 1, 0, 1, 0);
    for (int k = 3; k < 7; k++) add(1, 0, 1, 0, DW'(12'h100 + k), 1, 0, 1, 0);
    add(1, 0, 1, 0, 12'h107, 1, 1, 0, 0);
    add(1, 0, 1, 0, 12'h107, 0, 0, 0, 0);
    add(1, 0, 1, 0, 12'h100, 1, 0, 1, 0);
    for (int k = 1; k < 7; k++) add(1, 0, 0, 0, DW'(12'h100 + k), 1, 0, 1, 0);
    add(1, 0, 0, 0, 12'h107, 1, 1, 0, 0);
    add(1, 0, 0, 0, 12'h107, 0, 0, 0, 0);

    // reset values, held across edges
    step(); step();
    chk8("rst8", 0, 0, 0, 0, 0);
    chk6("rst6", 0, 0, 0, 0, 0);
    RST = 1'b1;

    foreach (tbl[i]) begin
      mode8 = tbl[i].mode; sel8 = tbl[i].sel;
      start8 = tbl[i].start; hold8 = tbl[i].hold;
      step();
      chk8($sformatf("v%0d", i), tbl[i].eout, tbl[i].ev, tbl[i].el, tbl[i].eb, tbl[i].ee);
    end

    // in_bus changes mid-scan are picked up at the emitting edge
    mode8 = 1; start8 = 1; step();
    chk8("live0", 12'h100, 1, 0, 1, 0);
    start8 = 0; step();
    chk8("live1", 12'h101, 1, 0, 1, 0);
    in8[2*DW +: DW] = 12'hABC; step();
    chk8("live2", 12'hABC, 1, 0, 1, 0);
    load_data();
    for (int k = 3; k < 8; k++) step();
    chk8("live7", 12'h107, 1, 1, 0, 0);
    step();

    // asynchronous reset mid-scan after word 0x102
    start8 = 1; step();
    start8 = 0; step(); step();
    chk8("pre_rst", 12'h102, 1, 0, 1, 0);
    #2 RST = 1'b0;
    #1 chk8("async_rst", 0, 0, 0, 0, 0);
    step();
    chk8("rst_held", 0, 0, 0, 0, 0);
    mode8 = 1; start8 = 1; RST = 1'b1;
    step();
    chk8("restart0", 12'h100, 1, 0, 1, 0);
    start8 = 0; step();
    chk8("restart1", 12'h101, 1, 0, 1, 0);
    for (int k = 2; k < 8; k++) step();
    chk8("restart7", 12'h107, 1, 1, 0, 0);

    // NUM_IN=6: out-of-range manual select, then a full scan
    mode6 = 0; sel6 = 7; step();
    chk6("oor7", 12'h200, 1, 0, 0, 1);
    sel6 = 6; step();
    chk6("oor6", 12'h200, 1, 0, 0, 1);
    sel6 = 5; step();
    chk6("sel5", 12'h205, 1, 0, 0, 0);
    mode6 = 1; start6 = 1; step();
    chk6("scan6_0", 12'h200, 1, 0, 1, 0);
    start6 = 0;
    for (int k = 1; k < 5; k++) begin
      step();
      chk6($sformatf("scan6_%0d", k), DW'(12'h200 + k), 1, 0, 1, 0);
    end
    step();
    chk6("scan6_5", 12'h205, 1, 1, 0, 0);
    step();
    chk6("scan6_gap", 12'h205, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
